// File: rtl/scan6_sequencer_if.sv
// Control/status bundle between a scan controller and scan6_sequencer.
// master drives the controls and observes the select code; slave is the sequencer.
interface scan6_sequencer_if #(
  parameter int unsigned DWELL_W = 8
);
  logic               run;
  logic               step;
  logic               dir;
  logic               load;
  logic [2:0]         load_val;
  logic [DWELL_W-1:0] dwell;
  logic [2:0]         code;
  logic               tick;
  logic               wrap;
  logic               busy;
  logic               err;

  modport master (
    output run, step, dir, load, load_val, dwell,
    input  code, tick, wrap, busy, err
  );

  modport slave (
    input  run, step, dir, load, load_val, dwell,
    output code, tick, wrap, busy, err
  );
endinterface

// File: rtl/scan6_sequencer.sv
// Select-code sequencer for a 3-to-6 decoder: steps code through 0..5
// with a programmable dwell, supporting free-run, single-step, direction and preload.
module scan6_sequencer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  scan6_sequencer_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STEP = 2'd2;

  logic [1:0]         state, state_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [2:0]         code_q, code_n;
  logic               tick_q, tick_n;
  logic               wrap_q, wrap_n;
  logic               busy_q, busy_n;
  logic               err_q, err_n;

  logic               adv_c;
  logic [2:0]         next_code_c;
  logic               next_wrap_c;

  // Modulo-6 neighbour of the current code; an out-of-range code recovers to 0 (up) or 5 (down)
  always_comb begin
    next_code_c = code_q;
    next_wrap_c = 1'b0;
    if (!bus.dir) begin
      if (code_q >= 3'd5) begin
        next_code_c = 3'd0;
        next_wrap_c = (code_q == 3'd5);
      end else begin
        next_code_c = code_q + 3'd1;
      end
    end else begin
      if (code_q == 3'd0 || code_q > 3'd5) begin
        next_code_c = 3'd5;
        next_wrap_c = (code_q == 3'd0);
      end else begin
        next_code_c = code_q - 3'd1;
      end
    end
  end

  assign adv_c = (state == S_RUN || state == S_STEP) && (cnt >= bus.dwell);

  // Next-state and next-output logic; load has priority over everything
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    code_n  = code_q;
    tick_n  = 1'b0;
    wrap_n  = 1'b0;
    err_n   = 1'b0;

    if (bus.load) begin
      state_n = S_IDLE;
      cnt_n   = '0;
      if (bus.load_val <= 3'd5) begin
        code_n = bus.load_val;
      end else begin
        err_n = 1'b1;
      end
    end else begin
      case (state)
        S_RUN: begin
          if (!bus.run) begin
            state_n = S_IDLE;
            cnt_n   = '0;
          end else if (adv_c) begin
            cnt_n  = '0;
            code_n = next_code_c;
            tick_n = 1'b1;
            wrap_n = next_wrap_c;
          end else begin
            cnt_n = cnt + DWELL_W'(1);
          end
        end
        S_STEP: begin
          if (adv_c) begin
            state_n = S_IDLE;
            cnt_n   = '0;
            code_n  = next_code_c;
            tick_n  = 1'b1;
            wrap_n  = next_wrap_c;
          end else begin
            cnt_n = cnt + DWELL_W'(1);
          end
        end
        S_IDLE: begin
          cnt_n = '0;
          if (bus.run) begin
            state_n = S_RUN;
          end else if (bus.step) begin
            state_n = S_STEP;
          end
        end
        default: begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      endcase
    end

    busy_n = (state_n == S_RUN) || (state_n == S_STEP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      code_q <= 3'd0;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      code_q <= code_n;
      tick_q <= tick_n;
      wrap_q <= wrap_n;
      busy_q <= busy_n;
      err_q  <= err_n;
    end
  end

  assign bus.code = code_q;
  assign bus.tick = tick_q;
  assign bus.wrap = wrap_q;
  assign bus.busy = busy_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_scan6_sequencer.sv
// Directed bench for scan6_sequencer; each observation compares {code,tick,wrap,busy,err}
// against hand-derived expectations.
module tb_scan6_sequencer;

  localparam int unsigned DWELL_W = 8;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  scan6_sequencer_if #(.DWELL_W(DWELL_W)) bus ();

  scan6_sequencer #(.DWELL_W(DWELL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] obs();
    return {bus.code, bus.tick, bus.wrap, bus.busy, bus.err};
  endfunction

  function automatic logic [6:0] ev(input int c, input bit t, input bit w, input bit b, input bit e);
    return {3'(c), t, w, b, e};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] exp_v;
    rst = 1'b1;
    bus.run = 1'b0; bus.step = 1'b0; bus.dir = 1'b0; bus.load = 1'b0;
    bus.load_val = 3'd0; bus.dwell = '0;
    cyc(); cyc();
    exp_v = ev(0, 0, 0, 0, 0);
    n_vec++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL reset got %b exp %b", obs(), exp_v);
    end
    rst = 1'b0;
    cyc();
    n_vec++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL reset_idle got %b exp %b", obs(), exp_v);
    end
  endtask

  task automatic test_free_run();
    logic [6:0] exp_v;
    bus.dwell = 8'd0; bus.dir = 1'b0; bus.run = 1'b1;
    cyc();
    exp_v = ev(0, 0, 0, 1, 0);
    n_vec++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL free_run_enter got %b exp %b", obs(), exp_v);
    end
    for (int i = 1; i <= 8; i++) begin
      cyc();
      exp_v = ev(i % 6, 1, (i % 6) == 0, 1, 0);
      n_vec++;
      if (obs() !== exp_v) begin
        n_err++;
        $display("FAIL free_run step=%0d got %b exp %b", i, obs(), exp_v);
      end
    end
    bus.run = 1'b0;
    cyc();
    exp_v = ev(2, 0, 0, 0, 0);
    n_vec++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL free_run_stop got %b exp %b", obs(), exp_v);
    end
  endtask

  task automatic test_dwell();
    logic [6:0] exp_v;
    bus.dwell = 8'd3; bus.dir = 1'b0; bus.run = 1'b1;
    cyc();
    exp_v = ev(2, 0, 0, 1, 0);
    n_vec++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL dwell_enter got %b exp %b", obs(), exp_v);
    end
    for (int k = 1; k <= 12; k++) begin
      cyc();
      exp_v = ev(2 + k / 4, (k % 4) == 0, 0, 1, 0);
      n_vec++;
      if (obs() !== exp_v) begin
        n_err++;
        $display("FAIL dwell k=%0d got %b exp %b", k, obs(), exp_v);
      end
    end
    bus.run = 1'b0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      exp_v = ev(5, 0, 0, 0, 0);
      n_vec++;
      if (obs() !== exp_v) begin
        n_err++;
        $display("FAIL dwell_frozen k=%0d got %b exp %b", k, obs(), exp_v);
      end
    end
  endtask

  task automatic test_load_down();
    logic [6:0] exp_v [5];
    exp_v[0] = ev(0, 0, 0, 0, 0);
    exp_v[1] = ev(0, 0, 0, 1, 0);
    exp_v[2] = ev(5, 1, 1, 1, 0);
    exp_v[3] = ev(4, 1, 0, 1, 0);
    exp_v[4] = ev(3, 1, 0, 1, 0);
    bus.load = 1'b1; bus.load_val = 3'd0; bus.dir = 1'b1; bus.dwell = 8'd0; bus.run = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      bus.load = 1'b0;
      n_vec++;
      if (obs() !== exp_v[k]) begin
        n_err++;
        $display("FAIL load_down k=%0d got %b exp %b", k, obs(), exp_v[k]);
      end
    end
    bus.run = 1'b0;
    cyc();
    bus.dir = 1'b0;
  endtask

  task automatic test_step();
    logic [6:0] exp_v [5];
    exp_v[0] = ev(3, 0, 0, 1, 0);
    exp_v[1] = ev(3, 0, 0, 1, 0);
    exp_v[2] = ev(3, 0, 0, 1, 0);
    exp_v[3] = ev(4, 1, 0, 0, 0);
    exp_v[4] = ev(4, 0, 0, 0, 0);
    bus.dwell = 8'd2; bus.dir = 1'b0; bus.step = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      bus.step = (k == 0);
      n_vec++;
      if (obs() !== exp_v[k]) begin
        n_err++;
        $display("FAIL step k=%0d got %b exp %b", k, obs(), exp_v[k]);
      end
    end
  endtask

  task automatic test_load_run();
    logic [6:0] exp_v [5];
    exp_v[0] = ev(4, 0, 0, 1, 0);
    exp_v[1] = ev(5, 1, 0, 1, 0);
    exp_v[2] = ev(4, 0, 0, 0, 0);
    exp_v[3] = ev(4, 0, 0, 0, 1);
    exp_v[4] = ev(4, 0, 0, 0, 0);
    bus.dwell = 8'd0; bus.dir = 1'b0; bus.run = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      n_vec++;
      if (obs() !== exp_v[k]) begin
        n_err++;
        $display("FAIL load_run k=%0d got %b exp %b", k, obs(), exp_v[k]);
      end
      case (k)
        1: begin bus.load = 1'b1; bus.load_val = 3'd4; end
        2: begin bus.load = 1'b1; bus.load_val = 3'd7; bus.run = 1'b0; end
        default: bus.load = 1'b0;
      endcase
    end
  endtask

  task automatic test_async_reset();
    logic [6:0] exp_v;
    bus.load = 1'b1; bus.load_val = 3'd2; bus.run = 1'b0; bus.dwell = 8'd0; bus.dir = 1'b0;
    cyc();
    bus.load = 1'b0; bus.run = 1'b1;
    cyc();
    cyc();
    exp_v = ev(3, 1, 0, 1, 0);
    n_vec++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL async_pre got %b exp %b", obs(), exp_v);
    end
    #2 rst = 1'b1;
    #1;
    exp_v = ev(0, 0, 0, 0, 0);
    n_vec++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL async_rst got %b exp %b", obs(), exp_v);
    end
    #1 rst = 1'b0;
    cyc();
    exp_v = ev(0, 0, 0, 1, 0);
    n_vec++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL async_resample got %b exp %b", obs(), exp_v);
    end
    cyc();
    exp_v = ev(1, 1, 0, 1, 0);
    n_vec++;
    if (obs() !== exp_v) begin
      n_err++;
      $display("FAIL async_first_adv got %b exp %b", obs(), exp_v);
    end
    bus.run = 1'b0;
    cyc();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_free_run();
    test_dwell();
    test_load_down();
    test_step();
    test_load_run();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
